// File: rtl/ntt_fifo_pkg.sv
// Shared geometry for the NTT/INTT delay-line FIFOs: stage counts, derived
// address widths, per-stage depth and the address type used by every stage.
package ntt_fifo_pkg;

  localparam int NTT_STAGE_CNT = 7;
  localparam int MUL_STAGE_CNT = 4;

  // Largest half-radix step, i.e. the depth of the first butterfly stage.
  localparam int MAX_HRS = 1 << (NTT_STAGE_CNT - 2);

  // The multiplier FIFO cycles through MUL_STAGE_CNT-1 slots; keep at least
  // one bit so a single-slot FIFO still has a legal (constant 0) address.
  localparam int MUL_STAGE_BITS =
    ((MUL_STAGE_CNT - 1) > 1) ? $clog2(MUL_STAGE_CNT - 1) : 1;

  localparam int MAX_FIFO2_ADDR_BITS =
    $clog2((MAX_HRS > MUL_STAGE_CNT) ? MAX_HRS : MUL_STAGE_CNT);

  typedef logic [MAX_FIFO2_ADDR_BITS-1:0] fifo2_addr_t;
  typedef logic [MUL_STAGE_BITS-1:0]      fifom_addr_t;

  // Butterfly stages halve their delay each step; the last stage instead
  // matches the multiplier pipeline depth.
  function automatic int stage_depth(input int s);
    if (s < NTT_STAGE_CNT - 1) begin
      return 1 << (NTT_STAGE_CNT - 2 - s);
    end
    return MUL_STAGE_CNT;
  endfunction

endpackage

// File: rtl/ntt_mod_counter.sv
// Modulo-DEPTH circular address counter with a fill/drain phase bit and a
// one-cycle wrap flag. A DEPTH of 1 keeps the address at 0 and toggles the
// phase on every enabled cycle.
module ntt_mod_counter #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         phase,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  logic at_last;
  assign at_last = (cnt == LAST);

  // Advance on inc, wrapping at DEPTH-1 and flipping the phase on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
      wrap  <= 1'b0;
    end else if (inc) begin
      if (at_last) begin
        cnt   <= '0;
        phase <= ~phase;
        wrap  <= 1'b1;
      end else begin
        cnt   <= cnt + W'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/ntt_fifo_addr_counter.sv
// Central address generator for the NTT/INTT delay-line FIFOs. One circular
// counter per butterfly stage plus one for the multiplier pipeline FIFO;
// every NTT/INTT instance consumes the same addresses so all buffers advance
// in lock-step.
module ntt_fifo_addr_counter
  import ntt_fifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en          [NTT_STAGE_CNT],
  output fifom_addr_t fifom_addr,
  output fifo2_addr_t fifo2_addr  [NTT_STAGE_CNT],
  output logic        stage_phase [NTT_STAGE_CNT],
  output logic        stage_wrap  [NTT_STAGE_CNT]
);

  logic any_en;
  logic fifom_phase;
  logic fifom_wrap;
  logic unused_fifom_status;

  // The multiplier FIFO moves whenever any stage moves.
  always_comb begin
    any_en = 1'b0;
    for (int i = 0; i < NTT_STAGE_CNT; i++) begin
      any_en = any_en | en[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NTT_STAGE_CNT; gi++) begin : g_stage
      ntt_mod_counter #(
        .DEPTH (stage_depth(gi)),
        .W     (MAX_FIFO2_ADDR_BITS)
      ) u_stage_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (en[gi]),
        .cnt   (fifo2_addr[gi]),
        .phase (stage_phase[gi]),
        .wrap  (stage_wrap[gi])
      );
    end
  endgenerate

  // Multiplier FIFO cycles through MUL_STAGE_CNT-1 slots.
  ntt_mod_counter #(
    .DEPTH (MUL_STAGE_CNT - 1),
    .W     (MUL_STAGE_BITS)
  ) u_fifom_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (any_en),
    .cnt   (fifom_addr),
    .phase (fifom_phase),
    .wrap  (fifom_wrap)
  );

  // Phase and wrap of the multiplier FIFO have no consumer.
  assign unused_fifom_status = fifom_phase ^ fifom_wrap;

endmodule

// File: tb/tb_ntt_fifo_addr_counter.sv
// Directed bench for ntt_fifo_addr_counter with default geometry
// (depths 32,16,8,4,2,1,4; multiplier FIFO modulo 3).
module tb_ntt_fifo_addr_counter;
  import ntt_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en          [NTT_STAGE_CNT];
  fifom_addr_t fifom_addr;
  fifo2_addr_t fifo2_addr  [NTT_STAGE_CNT];
  logic        stage_phase [NTT_STAGE_CNT];
  logic        stage_wrap  [NTT_STAGE_CNT];

  int tests_run = 0;
  int tests_failed = 0;

  // Hand-written stage depths for the default geometry.
  int depth_tbl [NTT_STAGE_CNT] = '{32, 16, 8, 4, 2, 1, 4};

  ntt_fifo_addr_counter dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .fifom_addr  (fifom_addr),
    .fifo2_addr  (fifo2_addr),
    .stage_phase (stage_phase),
    .stage_wrap  (stage_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en_all(input logic v);
    for (int i = 0; i < NTT_STAGE_CNT; i++) en[i] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < NTT_STAGE_CNT; i++) begin
      chk($sformatf("%s addr%0d", tag, i), 32'(fifo2_addr[i]), 0);
      chk($sformatf("%s phase%0d", tag, i), 32'(stage_phase[i]), 0);
      chk($sformatf("%s wrap%0d", tag, i), 32'(stage_wrap[i]), 0);
    end
    chk($sformatf("%s fifom", tag), 32'(fifom_addr), 0);
  endtask

  initial begin
    int fm;
    logic [5:0] gate_pat;
    int exp_a3 [6];
    int exp_p3 [6];

    rst = 1'b1;
    set_en_all(1'b0);
    #1;

    // Reset dominates random enables.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NTT_STAGE_CNT; i++) en[i] = 1'($urandom_range(0, 1));
      step();
      chk_all_zero($sformatf("rst_c%0d", c));
      $display("[TB] reset cycle %0d checked", c);
    end
    rst = 1'b0;
    set_en_all(1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk_all_zero($sformatf("idle_c%0d", c));
    end
    $display("[TB] idle after reset checked");

    // Stage 0 sweep, 33 enabled cycles.
    fm = 0;
    en[0] = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      step();
      fm = (fm + 1) % 3;
      chk($sformatf("s0 addr k%0d", k), 32'(fifo2_addr[0]), k % 32);
      chk($sformatf("s0 phase k%0d", k), 32'(stage_phase[0]), (k >= 32) ? 1 : 0);
      chk($sformatf("s0 wrap k%0d", k), 32'(stage_wrap[0]), (k == 32) ? 1 : 0);
      chk($sformatf("s0 fifom k%0d", k), 32'(fifom_addr), fm);
      for (int i = 1; i < NTT_STAGE_CNT; i++)
        chk($sformatf("s0 other addr%0d k%0d", i, k), 32'(fifo2_addr[i]), 0);
    end
    en[0] = 1'b0;
    $display("[TB] stage 0 sweep checked");

    // Depth-1 stage 5.
    en[5] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      fm = (fm + 1) % 3;
      chk($sformatf("s5 addr k%0d", k), 32'(fifo2_addr[5]), 0);
      chk($sformatf("s5 phase k%0d", k), 32'(stage_phase[5]), k % 2);
      chk($sformatf("s5 wrap k%0d", k), 32'(stage_wrap[5]), 1);
      chk($sformatf("s5 fifom k%0d", k), 32'(fifom_addr), fm);
    end
    en[5] = 1'b0;
    step();
    chk("s5 wrap drop", 32'(stage_wrap[5]), 0);
    chk("s5 fifom hold", 32'(fifom_addr), fm);
    chk("s0 addr hold", 32'(fifo2_addr[0]), 1);
    $display("[TB] depth-1 stage checked");

    // Gated enable on stage 3 (depth 4).
    gate_pat = 6'b101101;  // applied LSB first: 1,0,1,1,0,1
    exp_a3 = '{1, 1, 2, 3, 3, 0};
    exp_p3 = '{0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 6; k++) begin
      en[3] = gate_pat[k];
      step();
      if (gate_pat[k]) fm = (fm + 1) % 3;
      chk($sformatf("s3 addr k%0d", k), 32'(fifo2_addr[3]), exp_a3[k]);
      chk($sformatf("s3 phase k%0d", k), 32'(stage_phase[3]), exp_p3[k]);
      chk($sformatf("s3 wrap k%0d", k), 32'(stage_wrap[3]), (k == 5) ? 1 : 0);
      chk($sformatf("s3 fifom k%0d", k), 32'(fifom_addr), fm);
    end
    en[3] = 1'b0;
    $display("[TB] gated enable checked");

    // Fresh start, then every stage enabled for 64 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("rst2");
    fm = 0;
    set_en_all(1'b1);
    for (int k = 1; k <= 64; k++) begin
      step();
      fm = (fm + 1) % 3;
      for (int i = 0; i < NTT_STAGE_CNT; i++) begin
        chk($sformatf("all addr%0d k%0d", i, k), 32'(fifo2_addr[i]), k % depth_tbl[i]);
        chk($sformatf("all phase%0d k%0d", i, k), 32'(stage_phase[i]), (k / depth_tbl[i]) % 2);
        chk($sformatf("all wrap%0d k%0d", i, k), 32'(stage_wrap[i]),
            ((k % depth_tbl[i]) == 0) ? 1 : 0);
      end
      chk($sformatf("all fifom k%0d", k), 32'(fifom_addr), fm);
    end
    set_en_all(1'b0);
    $display("[TB] all-stage run checked");

    // Mid-run reset on stage 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    en[1] = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("s1 addr 10", 32'(fifo2_addr[1]), 10);
    chk("s1 fifom 10", 32'(fifom_addr), 1);
    rst = 1'b1;
    step();
    chk("midrst addr", 32'(fifo2_addr[1]), 0);
    chk("midrst phase", 32'(stage_phase[1]), 0);
    chk("midrst fifom", 32'(fifom_addr), 0);
    rst = 1'b0;
    step();
    chk("post rst addr", 32'(fifo2_addr[1]), 1);
    chk("post rst fifom", 32'(fifom_addr), 1);
    en[1] = 1'b0;
    $display("[TB] mid-run reset checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
